// File: rtl/dtp_core.sv
// Decision tree processor: walks one binary tree per sample and hands the leaf class downstream.
// Optional visit-limit guard against cyclic trees is compiled in with DTP_DEPTH_GUARD_EN.
module dtp_core #(
  parameter int ATTR_WIDTH  = 16,
  parameter int ATTR_ABIT   = 5,
  parameter int NODE_ABIT   = 8,
  parameter int CLASS_WIDTH = 4,
  parameter int MAX_DEPTH   = 16,
  localparam int NODE_WIDTH = 1 + ATTR_ABIT + ATTR_WIDTH + 2*NODE_ABIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_dtp_en,
  input  logic                   i_dtp_end,
  input  logic                   i_is_att_ram_avai,
  input  logic                   i_is_sample_done,
  output logic [ATTR_ABIT-1:0]   o_attr_sel,
  input  logic [ATTR_WIDTH-1:0]  i_attr_dout,
  output logic                   o_att_ram_switch,
  output logic [NODE_ABIT-1:0]   o_node_addr,
  input  logic [NODE_WIDTH-1:0]  i_node_data,
  output logic [CLASS_WIDTH-1:0] o_res_class,
  output logic                   o_res_vld,
  input  logic                   i_res_rdy,
  output logic [15:0]            o_res_cnt,
  output logic                   o_idle_done,
  output logic                   o_err
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, CMP, OUT, SWITCH} state_t;
  state_t state, state_nxt;

  logic                  node_leaf;
  logic [ATTR_ABIT-1:0]  node_attr;
  logic [ATTR_WIDTH-1:0] node_thr;
  logic [NODE_ABIT-1:0]  node_left, node_right;
  assign {node_leaf, node_attr, node_thr, node_left, node_right} = i_node_data;

  logic [ATTR_WIDTH-1:0] thr_q;
  logic [NODE_ABIT-1:0]  left_q, right_q;
  logic                  depth_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_dtp_en && i_is_att_ram_avai) state_nxt = FETCH;
      FETCH:   state_nxt = EVAL;
      EVAL:    state_nxt = (node_leaf || depth_hit) ? OUT : CMP;
      CMP:     state_nxt = FETCH;
      OUT:     if (i_res_rdy) state_nxt = SWITCH;
      SWITCH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_dtp_end) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_attr_sel       <= '0;
      o_node_addr      <= '0;
      o_res_class      <= '0;
      o_res_vld        <= 1'b0;
      o_att_ram_switch <= 1'b0;
      o_res_cnt        <= '0;
      thr_q            <= '0;
      left_q           <= '0;
      right_q          <= '0;
    end else if (i_dtp_end) begin
      // Abort drops any pending result without releasing the buffer.
      o_res_vld        <= 1'b0;
      o_res_cnt        <= '0;
      o_att_ram_switch <= 1'b0;
    end else begin
      o_att_ram_switch <= 1'b0;
      case (state)
        IDLE: if (i_dtp_en && i_is_att_ram_avai) o_node_addr <= '0;
        EVAL: begin
          if (node_leaf) begin
            o_res_class <= node_thr[CLASS_WIDTH-1:0];
            o_res_vld   <= 1'b1;
          end else if (depth_hit) begin
            o_res_class <= '1;
            o_res_vld   <= 1'b1;
          end else begin
            o_attr_sel <= node_attr;
            thr_q      <= node_thr;
            left_q     <= node_left;
            right_q    <= node_right;
          end
        end
        CMP: o_node_addr <= (i_attr_dout <= thr_q) ? left_q : right_q;
        OUT: if (i_res_rdy) begin
          o_res_vld        <= 1'b0;
          o_res_cnt        <= o_res_cnt + 16'd1;
          o_att_ram_switch <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DTP_DEPTH_GUARD_EN
  localparam int VW = $clog2(MAX_DEPTH + 1);
  logic [VW-1:0] visits;
  logic          err_q;

  assign depth_hit = (visits == VW'(MAX_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      visits <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE)      visits <= '0;
      else if (state == EVAL) visits <= visits + VW'(1);
      err_q <= !i_dtp_end && (state == EVAL) && !node_leaf && depth_hit;
    end
  end
  assign o_err = err_q;
`else
  assign depth_hit = 1'b0;
  assign o_err     = 1'b0;
`endif

  assign o_idle_done = (state == IDLE) && i_is_sample_done;

endmodule

// File: tb/tb_dtp_core.sv
// Self-checking bench for dtp_core: directed cases plus random trees checked against a tree-walk model.
module tb_dtp_core;
  localparam int AW = 16, AB = 5, NB = 8, CW = 4;
  localparam int NW = 1 + AB + AW + 2*NB;
`ifdef DTP_DEPTH_GUARD_EN
  localparam int MD = 4;
  localparam int TD = 3;
`else
  localparam int MD = 16;
  localparam int TD = 4;
`endif

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, dend = 1'b0, avai = 1'b0, sdone = 1'b1, rdy = 1'b0;
  logic [AB-1:0] attr_sel;
  logic [AW-1:0] attr_dout;
  logic          ram_switch, res_vld, idle_done, err;
  logic [NB-1:0] node_addr;
  logic [NW-1:0] node_q;
  logic [CW-1:0] res_class;
  logic [15:0]   res_cnt;

  logic [AW-1:0] attr [32];
  logic [NW-1:0] nmem [256];

  assign attr_dout = attr[attr_sel];
  always @(posedge clk) node_q <= nmem[node_addr];
  always #5 clk = ~clk;

  dtp_core #(.ATTR_WIDTH(AW), .ATTR_ABIT(AB), .NODE_ABIT(NB), .CLASS_WIDTH(CW), .MAX_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .i_dtp_en(en), .i_dtp_end(dend), .i_is_att_ram_avai(avai),
    .i_is_sample_done(sdone), .o_attr_sel(attr_sel), .i_attr_dout(attr_dout),
    .o_att_ram_switch(ram_switch), .o_node_addr(node_addr), .i_node_data(node_q),
    .o_res_class(res_class), .o_res_vld(res_vld), .i_res_rdy(rdy), .o_res_cnt(res_cnt),
    .o_idle_done(idle_done), .o_err(err)
  );

  int checks = 0, errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk(input logic lf, input logic [AB-1:0] a,
                                       input logic [AW-1:0] t, input logic [NB-1:0] l,
                                       input logic [NB-1:0] r);
    return {lf, a, t, l, r};
  endfunction

  // Reference: follow the tree from the root using the current attribute vector.
  task automatic walk(output int cls, output int depth, output int root_attr);
    int addr;
    int a;
    logic [AW-1:0] t;
    addr = 0;
    depth = 0;
    root_attr = int'(nmem[0][NW-2 -: AB]);
    while (!nmem[addr][NW-1] && depth < 64) begin
      a = int'(nmem[addr][NW-2 -: AB]);
      t = nmem[addr][2*NB +: AW];
      addr = (attr[a] <= t) ? int'(nmem[addr][NB +: NB]) : int'(nmem[addr][0 +: NB]);
      depth++;
    end
    cls = int'(nmem[addr][2*NB +: CW]);
  endtask

  // One full sample: start, latency, class, hold under backpressure, handshake, switch, return to idle.
  task automatic run_sample(input int exp_cls, input int exp_depth, input int exp_ra,
                            input int hold, input int exp_err);
    int cyc;
    @(negedge clk);
    en = 1'b1; avai = 1'b1; rdy = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("start_addr", 32'(node_addr), 0);
      if (cyc == 3 && exp_depth > 0) chk("attr_sel_cmp", 32'(attr_sel), 32'(exp_ra));
    end while (!res_vld && cyc < 400);
    chk("latency", 32'(cyc), 32'(3*exp_depth + 3));
    chk("class", 32'(res_class), 32'(exp_cls));
    chk("err_pulse", 32'(err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_vld", 32'(res_vld), 1);
      chk("hold_class", 32'(res_class), 32'(exp_cls));
      chk("hold_no_switch", 32'(ram_switch), 0);
      chk("hold_err_low", 32'(err), 0);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("vld_drop", 32'(res_vld), 0);
    chk("switch_pulse", 32'(ram_switch), 1);
    chk("res_cnt", 32'(res_cnt), 32'(exp_cnt));
    chk("busy_in_switch", 32'(idle_done), 0);
    @(negedge clk);
    chk("switch_end", 32'(ram_switch), 0);
    chk("idle_after_switch", 32'(idle_done), 1);
    avai = 1'b0;
    @(negedge clk);
    chk("no_restart", 32'(idle_done), 1);
  endtask

  initial begin
    int cls, dep, ra, a, d, k;
    logic internal;
    for (int i = 0; i < 256; i++) nmem[i] = '0;
    for (int i = 0; i < 32; i++) attr[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(res_vld), 0);
    chk("rst_class", 32'(res_class), 0);
    chk("rst_switch", 32'(ram_switch), 0);
    chk("rst_cnt", 32'(res_cnt), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_attr_sel", 32'(attr_sel), 0);
    chk("rst_node_addr", 32'(node_addr), 0);
    chk("rst_idle", 32'(idle_done), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_avai", 32'(idle_done), 1);

    // Root leaf, class 5.
    nmem[0] = mk(1'b1, '0, AW'(5), '0, '0);
    run_sample(5, 0, 0, 0, 0);

    // Root compares attr[2] against 100; equality goes left.
    nmem[0] = mk(1'b0, AB'(2), AW'(100), NB'(1), NB'(2));
    nmem[1] = mk(1'b1, '0, AW'(1), '0, '0);
    nmem[2] = mk(1'b1, '0, AW'(2), '0, '0);
    attr[2] = AW'(100);
    run_sample(1, 1, 2, 0, 0);
    attr[2] = AW'(101);
    run_sample(2, 1, 2, 10, 0);

    // Abort during CMP.
    @(negedge clk);
    en = 1'b1; avai = 1'b1;
    repeat (3) @(negedge clk);
    dend = 1'b1; avai = 1'b0;
    @(negedge clk);
    dend = 1'b0;
    exp_cnt = 0;
    chk("end_idle", 32'(idle_done), 1);
    chk("end_vld", 32'(res_vld), 0);
    chk("end_cnt", 32'(res_cnt), 0);
    chk("end_switch", 32'(ram_switch), 0);
    repeat (4) @(negedge clk);
    chk("end_no_result", 32'(res_vld), 0);
    chk("end_no_switch", 32'(ram_switch), 0);
    run_sample(2, 1, 2, 1, 0);

    // Random trees in heap layout; thresholds sometimes equal the attribute to hit the <= edge.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 32; i++) attr[i] = AW'($urandom);
      for (int i = 0; i < 31; i++) begin
        d = 0; k = i;
        while (k > 0) begin k = (k - 1) / 2; d++; end
        internal = (d < TD) && ($urandom_range(3) != 0);
        a = int'($urandom_range(31));
        nmem[i] = mk(!internal, AB'(a), ($urandom_range(2) == 0) ? attr[a] : AW'($urandom),
                     NB'(2*i + 1), NB'(2*i + 2));
      end
      walk(cls, dep, ra);
      run_sample(cls, dep, ra, int'($urandom_range(2)), 0);
    end

`ifdef DTP_DEPTH_GUARD_EN
    // Root points back to itself on both sides; the guard must fire on the MD-th visit.
    nmem[0] = mk(1'b0, AB'(1), AW'(7), '0, '0);
    run_sample((1 << CW) - 1, MD - 1, 1, 1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
